apu_dmc_fifo: RTL

Parametrised DPCM sample channel for the APU, successor to the single-buffer DMC channel. Fetches 1-bit delta-encoded sample bytes through the DMA engine into a FIFO_DEPTH-byte prefetch FIFO, then plays them out as an LEVEL_W-bit level to the mixer at a programmable rate. Supports loop and IRQ-at-end, and a configurable delta step. Sits on the APU register bus ($4010/$4011/$4013/$4015) beside the pulse, triangle and noise channels.

---
 rtl/apu_dmc_fifo.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/apu_dmc_fifo.sv
// DPCM sample channel: DMA-fed byte prefetch FIFO feeding a 1-bit delta
// playback unit with programmable rate, loop and end-of-sample IRQ.
module apu_dmc_fifo #(
    parameter int FIFO_DEPTH = 2,
    parameter int LEVEL_W    = 7,
    parameter int STEP       = 2,
    parameter int LEN_SHIFT  = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             apu_cycle,
    input  logic [4:0]                       apu_addr,
    input  logic [7:0]                       data_in,
    input  logic                             apu_wr,
    input  logic                             dmc_read,
    output logic                             active,
    output logic [LEVEL_W-1:0]               sample,
    output logic                             irq,
    output logic                             dma_init,
    output logic                             dma_req,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW = 8 + LEN_SHIFT + 1;

    localparam logic [LEVEL_W:0] UP_LIM =
        (LEVEL_W+1)'((1 << LEVEL_W) - 1 - STEP);
    localparam logic [LEVEL_W:0] DN_LIM = (LEVEL_W+1)'(STEP);

    logic               irq_en;
    logic               loop_en;
    logic [3:0]         rate;
    logic [7:0]         len;
    logic [BW-1:0]      br;
    logic [8:0]         timer;
    logic [7:0]         sr;
    logic [3:0]         bits;
    logic               silence;
    logic [LEVEL_W-1:0] level;
    logic [CW-1:0]      cnt;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [7:0]         mem [FIFO_DEPTH];

    logic               wr_ctl;
    logic               wr_dac;
    logic               wr_len;
    logic               wr_sts;
    logic               sts_dis;
    logic               start;
    logic               full;
    logic               empty;
    logic               push;
    logic               last;
    logic               tick;
    logic               pop;
    logic               up_ok;
    logic               dn_ok;
    logic [BW-1:0]      reload;
    logic [LEVEL_W-1:0] dac_val;

    function automatic logic [8:0] period(input logic [3:0] r);
        case (r)
            4'd0:    return 9'd214;
            4'd1:    return 9'd190;
            4'd2:    return 9'd170;
            4'd3:    return 9'd160;
            4'd4:    return 9'd143;
            4'd5:    return 9'd127;
            4'd6:    return 9'd113;
            4'd7:    return 9'd107;
            4'd8:    return 9'd95;
            4'd9:    return 9'd80;
            4'd10:   return 9'd71;
            4'd11:   return 9'd64;
            4'd12:   return 9'd53;
            4'd13:   return 9'd42;
            4'd14:   return 9'd36;
            default: return 9'd27;
        endcase
    endfunction

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wr_ctl  = apu_wr && (apu_addr == 5'h10);
    assign wr_dac  = apu_wr && (apu_addr == 5'h11);
    assign wr_len  = apu_wr && (apu_addr == 5'h13);
    assign wr_sts  = apu_wr && (apu_addr == 5'h15);
    assign sts_dis = wr_sts && !data_in[4];

    assign active  = (br != '0);
    assign full    = (cnt == CW'(FIFO_DEPTH));
    assign empty   = (cnt == '0);
    assign start   = wr_sts && data_in[4] && !active;
    assign push    = dmc_read && active && !full && !sts_dis;
    assign last    = push && (br == BW'(1));
    assign reload  = (BW'(len) << LEN_SHIFT) + BW'(1);

    assign tick    = apu_cycle && (timer == '0);
    assign pop     = tick && (bits == 4'd1) && !empty;
    assign up_ok   = {1'b0, level} <= UP_LIM;
    assign dn_ok   = {1'b0, level} >= DN_LIM;
    assign dac_val = LEVEL_W'(data_in[6:0]) << (LEVEL_W - 7);

    assign dma_req    = active && !full && !dma_init;
    assign sample     = level;
    assign fifo_level = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en   <= 1'b0;
            loop_en  <= 1'b0;
            rate     <= '0;
            len      <= '0;
            br       <= '0;
            dma_init <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr_ctl) begin
                irq_en  <= data_in[7];
                loop_en <= data_in[6];
                rate    <= data_in[3:0];
            end
            if (wr_len)
                len <= data_in;
            if (sts_dis)
                br <= '0;
            else if (start)
                br <= reload;
            else if (push)
                br <= (last && loop_en) ? reload : br - BW'(1);
            dma_init <= start || (last && loop_en);
            // Clearing takes priority over a same-edge set
            if (wr_sts || !irq_en)
                irq <= 1'b0;
            else if (last && !loop_en)
                irq <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= nxt(wr_ptr);
            if (pop)
                rd_ptr <= nxt(rd_ptr);
            if (push && !pop)
                cnt <= cnt + CW'(1);
            else if (pop && !push)
                cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer   <= '0;
            sr      <= '0;
            bits    <= 4'd8;
            silence <= 1'b1;
            level   <= '0;
        end else begin
            if (apu_cycle)
                timer <= tick ? period(rate) - 9'd1 : timer - 9'd1;
            // A direct level write overrides the delta step
            if (wr_dac)
                level <= dac_val;
            else if (tick && !silence) begin
                if (sr[0] && up_ok)
                    level <= level + LEVEL_W'(STEP);
                else if (!sr[0] && dn_ok)
                    level <= level - LEVEL_W'(STEP);
            end
            if (tick) begin
                sr <= sr >> 1;
                if (bits == 4'd1) begin
                    bits <= 4'd8;
                    if (!empty) begin
                        sr      <= mem[rd_ptr];
                        silence <= 1'b0;
                    end else
                        silence <= 1'b1;
                end else
                    bits <= bits - 4'd1;
            end
        end
    end

endmodule
